line_fill_buffer: RTL and testbench
===================================

LINE_FILL_BUFFER -- requirements
Module: line_fill_buffer

Interface
REQ-001 The block SHALL have parameter FE_DATA_W, default 32, meaning front-end word width in bits.
REQ-002 The block SHALL have parameter BE_DATA_W, default FE_DATA_W, meaning back-end word width in bits, a power-of-two multiple of FE_DATA_W.
REQ-003 The block SHALL have parameter WORD_OFF_W, default 3, meaning log2 of front-end words per cache line.
REQ-004 The block SHALL have local parameters:
- LINE2MEM_W = WORD_OFF_W - log2(BE_DATA_W/FE_DATA_W), the back-end words-per-line offset; supported only for LINE2MEM_W >= 1.
- NBE = 2^LINE2MEM_W.
- LINE_W = FE_DATA_W*2^WORD_OFF_W.
REQ-005 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-006 clk  input  1  clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 replace  input  1  high while the upstream read channel is replacing a line.
REQ-009 read_valid  input  1  qualifies read_addr/read_rdata for one cycle.
REQ-010 read_addr  input  LINE2MEM_W  back-end word slot of read_rdata, valid with read_valid.
REQ-011 read_rdata  input  BE_DATA_W  back-end word returned by memory.
REQ-012 fe_word_off  input  WORD_OFF_W  front-end word requested by the stalled cache access.
REQ-013 line_data  output  LINE_W  assembled line, slot k at bits [(k+1)*BE_DATA_W-1 : k*BE_DATA_W].
REQ-014 word_valid  output  NBE  per-slot received mask.
REQ-015 fe_ready  output  1  requested front-end word is available this cycle.
REQ-016 fe_rdata  output  FE_DATA_W  requested front-end word.
REQ-017 line_done  output  1  single-cycle pulse when all NBE slots received.
REQ-018 fill_abort  output  1  single-cycle pulse when replace drops before the line is complete.

Function
REQ-019 The FSM SHALL have states IDLE, FILL, DONE.
REQ-020 Transitions:
- IDLE: replace=1 moves to FILL and clears word_valid to 0 on the same edge.
- FILL: replace=0 moves to IDLE.
- DONE: replace=0 moves to IDLE.
REQ-021 In FILL, read_valid=1 SHALL write read_rdata into slot read_addr of line_data and set word_valid[read_addr] on the next edge.
REQ-022 A repeated write to an already-valid slot SHALL overwrite the data; word_valid is unchanged.
REQ-023 When the FILL write makes word_valid all ones, the FSM SHALL move to DONE, and line_done SHALL be 1 for exactly the first cycle in DONE.
REQ-024 read_valid SHALL be ignored in IDLE and DONE.
REQ-025 Slot selection: slot = fe_word_off[WORD_OFF_W-1 : WORD_OFF_W-LINE2MEM_W]; the FE lane within the slot is the remaining low bits.
REQ-026 fe_ready SHALL be 1 when the state is FILL or DONE and word_valid[slot]=1; fe_rdata then SHALL be the selected lane of line_data.
REQ-027 Bypass: in FILL with read_valid=1 and read_addr=slot, fe_ready SHALL be 1 combinationally in that cycle, with fe_rdata taken from read_rdata.
REQ-028 Outside REQ-026/REQ-027, fe_ready SHALL be 0; fe_rdata is don't-care but SHALL equal the line_data lane.
REQ-029 replace=0 in FILL with word_valid not all ones SHALL pulse fill_abort for one cycle and return to IDLE; word_valid and line_data are retained.
REQ-030 If, in FILL, replace=0 coincides with a read_valid write that completes the line, the write SHALL be captured, line_done SHALL pulse next cycle, fill_abort SHALL stay 0, and the next state SHALL be IDLE.
REQ-031 line_data and word_valid SHALL hold their values in IDLE until the next replace rising start.

Reset
REQ-032 On reset=1 at a clock edge, the block SHALL set:
- state IDLE;
- word_valid=0, line_done=0, fill_abort=0, fe_ready=0.
line_data is not reset.
REQ-033 Reset SHALL override any in-progress fill, with no line_done or fill_abort pulse.

Verification
REQ-034 Default params (NBE=8): replace=1, then 8 read_valid beats with read_addr 0..7 and data 0x10..0x17 -> word_valid=0xFF, line_done one pulse, line_data slot k=0x10+k.
REQ-035 fe_word_off=5, beats in order 0..7 -> fe_ready first 1 in the beat-5 cycle (bypass, fe_rdata=0x15), then stays 1.
REQ-036 Gaps between beats, beat 3 repeated with 0xAA then 0xBB -> slot 3=0xBB, word_valid counts 8 distinct slots, line_done once.
REQ-037 replace drops after 4 beats -> fill_abort one pulse, IDLE, word_valid=0x0F; a new replace clears the mask.
REQ-038 reset asserted mid-fill after 3 beats -> next cycle IDLE, word_valid=0, no line_done/fill_abort.
REQ-039 BE_DATA_W=64, FE_DATA_W=32, WORD_OFF_W=3 (NBE=4) -> fe_word_off=6/7 select low/high half of slot 3.

Source files
------------

// File: rtl/line_fill_buffer.sv
// Line fill buffer: assembles back-end beats into a cache line and
// serves the stalled front-end word as soon as its slot arrives.
module line_fill_buffer #(
    parameter int FE_DATA_W  = 32,
    parameter int BE_DATA_W  = FE_DATA_W,
    parameter int WORD_OFF_W = 3,
    localparam int RATIO      = BE_DATA_W / FE_DATA_W,
    localparam int LINE2MEM_W = WORD_OFF_W - $clog2(RATIO),
    localparam int NBE        = 2 ** LINE2MEM_W,
    localparam int LINE_W     = FE_DATA_W * (2 ** WORD_OFF_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  replace,
    input  logic                  read_valid,
    input  logic [LINE2MEM_W-1:0] read_addr,
    input  logic [BE_DATA_W-1:0]  read_rdata,
    input  logic [WORD_OFF_W-1:0] fe_word_off,
    output logic [LINE_W-1:0]     line_data,
    output logic [NBE-1:0]        word_valid,
    output logic                  fe_ready,
    output logic [FE_DATA_W-1:0]  fe_rdata,
    output logic                  line_done,
    output logic                  fill_abort
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                         state;
    logic [NBE-1:0][BE_DATA_W-1:0]  line_q;
    logic [NBE-1:0]                 hit;
    logic [NBE-1:0]                 wv_next;
    logic [LINE2MEM_W-1:0]          slot;
    logic [WORD_OFF_W-1:0]          lane;
    logic                           bypass;

    assign line_data = line_q;
    assign hit       = read_valid ? (NBE'(1) << read_addr) : '0;
    assign wv_next   = word_valid | hit;

    assign slot   = fe_word_off[WORD_OFF_W-1 -: LINE2MEM_W];
    assign lane   = fe_word_off & WORD_OFF_W'(RATIO - 1);
    assign bypass = (state == FILL) && read_valid && (read_addr == slot);

    // The beat arriving this cycle beats the stored copy to the front end.
    always_comb begin
        fe_ready = bypass || ((state != IDLE) && word_valid[slot]);
        if (bypass)
            fe_rdata = read_rdata[int'(lane)*FE_DATA_W +: FE_DATA_W];
        else
            fe_rdata = line_q[slot][int'(lane)*FE_DATA_W +: FE_DATA_W];
    end

    always_ff @(posedge clk) begin
        line_done  <= 1'b0;
        fill_abort <= 1'b0;
        if (reset) begin
            state      <= IDLE;
            word_valid <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (replace) begin
                        state      <= FILL;
                        word_valid <= '0;
                    end
                end
                FILL: begin
                    if (read_valid)
                        line_q[read_addr] <= read_rdata;
                    word_valid <= wv_next;
                    // A completing beat wins over a dropping replace.
                    if (&wv_next) begin
                        line_done <= 1'b1;
                        state     <= replace ? DONE : IDLE;
                    end else if (!replace) begin
                        fill_abort <= 1'b1;
                        state      <= IDLE;
                    end
                end
                DONE: begin
                    if (!replace)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_buffer.sv
// Randomised and directed checks of line_fill_buffer against a
// behavioural line model, plus a 64/32-bit width variant.
module tb_line_fill_buffer;

    logic         clk;
    logic         reset;
    logic         replace;
    logic         read_valid;
    logic [2:0]   read_addr;
    logic [31:0]  read_rdata;
    logic [2:0]   fe_word_off;
    logic [255:0] line_data;
    logic [7:0]   word_valid;
    logic         fe_ready;
    logic [31:0]  fe_rdata;
    logic         line_done;
    logic         fill_abort;

    logic         r2_reset;
    logic         r2_replace;
    logic         r2_read_valid;
    logic [1:0]   r2_read_addr;
    logic [63:0]  r2_read_rdata;
    logic [2:0]   r2_fe_word_off;
    logic [255:0] r2_line_data;
    logic [3:0]   r2_word_valid;
    logic         r2_fe_ready;
    logic [31:0]  r2_fe_rdata;
    logic         r2_line_done;
    logic         r2_fill_abort;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    typedef enum {S_IDLE, S_FILL, S_DONE} ph_t;
    ph_t         m_ph = S_IDLE;
    bit          m_valid [8];
    logic [31:0] m_line  [8];
    bit          m_done = 0;
    bit          m_abort = 0;

    line_fill_buffer u_dut (
        .clk(clk), .reset(reset), .replace(replace),
        .read_valid(read_valid), .read_addr(read_addr),
        .read_rdata(read_rdata), .fe_word_off(fe_word_off),
        .line_data(line_data), .word_valid(word_valid),
        .fe_ready(fe_ready), .fe_rdata(fe_rdata),
        .line_done(line_done), .fill_abort(fill_abort)
    );

    line_fill_buffer #(
        .FE_DATA_W(32), .BE_DATA_W(64), .WORD_OFF_W(3)
    ) u_dut2 (
        .clk(clk), .reset(r2_reset), .replace(r2_replace),
        .read_valid(r2_read_valid), .read_addr(r2_read_addr),
        .read_rdata(r2_read_rdata), .fe_word_off(r2_fe_word_off),
        .line_data(r2_line_data), .word_valid(r2_word_valid),
        .fe_ready(r2_fe_ready), .fe_rdata(r2_fe_rdata),
        .line_done(r2_line_done), .fill_abort(r2_fill_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int n_valid();
        int n = 0;
        for (int k = 0; k < 8; k++) n += m_valid[k];
        return n;
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] m = '0;
        for (int k = 0; k < 8; k++) m[k] = m_valid[k];
        return m;
    endfunction

    // Model update at the edge, comparison mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            m_done  = 0;
            m_abort = 0;
            if (reset) begin
                m_ph = S_IDLE;
                for (int k = 0; k < 8; k++) m_valid[k] = 0;
            end else if (m_ph == S_IDLE) begin
                if (replace) begin
                    m_ph = S_FILL;
                    for (int k = 0; k < 8; k++) m_valid[k] = 0;
                end
            end else if (m_ph == S_FILL) begin
                if (read_valid) begin
                    m_line[read_addr]  = read_rdata;
                    m_valid[read_addr] = 1;
                end
                if (n_valid() == 8) begin
                    m_done = 1;
                    m_ph   = replace ? S_DONE : S_IDLE;
                end else if (!replace) begin
                    m_abort = 1;
                    m_ph    = S_IDLE;
                end
            end else if (!replace) begin
                m_ph = S_IDLE;
            end
            @(negedge clk);
            if (line_done) done_cnt++;
            if (fill_abort) abort_cnt++;
            #2;
            begin
                bit byp;
                bit rdy;
                int s;
                s   = int'(fe_word_off);
                byp = (m_ph == S_FILL) && read_valid && (read_addr == fe_word_off);
                rdy = byp || ((m_ph != S_IDLE) && m_valid[s]);
                chk("cyc_word_valid", 64'(word_valid), 64'(m_mask()));
                chk("cyc_line_done", 64'(line_done), 64'(m_done));
                chk("cyc_fill_abort", 64'(fill_abort), 64'(m_abort));
                chk("cyc_fe_ready", 64'(fe_ready), 64'(rdy));
                if (rdy)
                    chk("cyc_fe_rdata", 64'(fe_rdata),
                        64'(byp ? read_rdata : m_line[s]));
                for (int k = 0; k < 8; k++)
                    if (m_valid[k])
                        chk("cyc_line_slot", 64'(line_data[k*32 +: 32]),
                            64'(m_line[k]));
            end
        end
    end

    task automatic set_in(input bit rst, input bit rep, input bit rv,
                          input int a, input logic [31:0] d, input int off);
        reset       = rst;
        replace     = rep;
        read_valid  = rv;
        read_addr   = 3'(a);
        read_rdata  = d;
        fe_word_off = 3'(off);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input bit rst, input bit rep, input bit rv,
                       input int a, input logic [31:0] d, input int off);
        set_in(rst, rep, rv, a, d, off);
        tick();
    endtask

    initial begin
        int d0;
        int a0;
        set_in(1, 0, 0, 0, 0, 0);
        r2_reset = 1; r2_replace = 0; r2_read_valid = 0;
        r2_read_addr = 0; r2_read_rdata = 0; r2_fe_word_off = 0;
        tick();
        tick();
        chk("rst_word_valid", 64'(word_valid), 64'h0);
        chk("rst_line_done", 64'(line_done), 64'h0);
        chk("rst_fill_abort", 64'(fill_abort), 64'h0);
        chk("rst_fe_ready", 64'(fe_ready), 64'h0);

        // Full fill in order, front end waiting on word 5.
        drv(0, 1, 0, 0, 0, 5);
        d0 = done_cnt;
        for (int k = 0; k < 8; k++) begin
            set_in(0, 1, 1, k, 32'h10 + 32'(k), 5);
            #1;
            if (k == 4) chk("w5_not_ready", 64'(fe_ready), 64'h0);
            if (k >= 5) chk("w5_ready", 64'(fe_ready), 64'h1);
            if (k == 5) chk("w5_bypass", 64'(fe_rdata), 64'h15);
            tick();
        end
        set_in(0, 1, 0, 0, 0, 5);
        chk("fill_mask", 64'(word_valid), 64'hFF);
        chk("fill_done", 64'(line_done), 64'h1);
        chk("fill_slot0", 64'(line_data[31:0]), 64'h10);
        chk("fill_slot7", 64'(line_data[255:224]), 64'h17);
        chk("w5_stored", 64'(fe_rdata), 64'h15);
        tick();
        chk("done_once", 64'(done_cnt - d0), 64'h1);

        // Gaps and a repeated slot.
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0);
        d0 = done_cnt;
        drv(0, 1, 1, 0, 32'h20, 0);
        drv(0, 1, 1, 1, 32'h21, 0);
        drv(0, 1, 0, 0, 0, 0);
        drv(0, 1, 1, 3, 32'hAA, 0);
        drv(0, 1, 0, 0, 0, 0);
        drv(0, 1, 1, 3, 32'hBB, 0);
        chk("rep_mask", 64'(word_valid), 64'h0B);
        for (int k = 2; k < 8; k++)
            if (k != 3) drv(0, 1, 1, k, 32'h20 + 32'(k), 0);
        drv(0, 1, 0, 0, 0, 0);
        chk("rep_slot3", 64'(line_data[127:96]), 64'hBB);
        chk("rep_done_once", 64'(done_cnt - d0), 64'h1);

        // Abort after four beats.
        drv(0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0);
        a0 = abort_cnt;
        for (int k = 0; k < 4; k++) drv(0, 1, 1, k, 32'h30 + 32'(k), 0);
        drv(0, 0, 0, 0, 0, 0);
        chk("abort_pulse", 64'(fill_abort), 64'h1);
        chk("abort_mask", 64'(word_valid), 64'h0F);
        drv(0, 0, 1, 4, 32'h99, 4);
        chk("abort_once", 64'(abort_cnt - a0), 64'h1);
        chk("abort_mask_held", 64'(word_valid), 64'h0F);
        drv(0, 1, 0, 0, 0, 0);
        chk("replace_clears", 64'(word_valid), 64'h0);

        // Reset mid-fill after three beats.
        d0 = done_cnt;
        a0 = abort_cnt;
        for (int k = 0; k < 3; k++) drv(0, 1, 1, k, 32'h40 + 32'(k), 0);
        drv(1, 1, 1, 3, 32'h43, 0);
        chk("rst_mid_mask", 64'(word_valid), 64'h0);
        set_in(0, 0, 1, 2, 32'h55, 2);
        #1;
        chk("rst_mid_idle", 64'(fe_ready), 64'h0);
        tick();
        chk("rst_mid_pulses", 64'((done_cnt - d0) + (abort_cnt - a0)), 64'h0);

        // Completing beat coincides with replace dropping.
        drv(0, 1, 0, 0, 0, 0);
        a0 = abort_cnt;
        for (int k = 0; k < 7; k++) drv(0, 1, 1, k, 32'h50 + 32'(k), 0);
        drv(0, 0, 1, 7, 32'h57, 0);
        chk("late_done", 64'(line_done), 64'h1);
        chk("late_no_abort", 64'(abort_cnt - a0), 64'h0);
        chk("late_slot7", 64'(line_data[255:224]), 64'h57);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++)
            drv($urandom_range(99) == 0, $urandom_range(29) != 0,
                $urandom_range(1) == 1, int'($urandom_range(7)),
                $urandom, int'($urandom_range(7)));

        // 64-bit back end, 32-bit front end.
        drv(0, 0, 0, 0, 0, 0);
        r2_reset = 0;
        r2_replace = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            r2_read_valid  = 1;
            r2_read_addr   = 2'(k);
            r2_read_rdata  = {32'h2000_0000 + 32'(k), 32'h1000_0000 + 32'(k)};
            r2_fe_word_off = 3'd6;
            #1;
            if (k == 2) chk("w2_not_ready", 64'(r2_fe_ready), 64'h0);
            if (k == 3) begin
                chk("w2_byp_ready", 64'(r2_fe_ready), 64'h1);
                chk("w2_byp_lo", 64'(r2_fe_rdata), 64'h1000_0003);
                r2_fe_word_off = 3'd7;
                #1;
                chk("w2_byp_hi", 64'(r2_fe_rdata), 64'h2000_0003);
            end
            tick();
        end
        r2_read_valid = 0;
        chk("w2_mask", 64'(r2_word_valid), 64'hF);
        chk("w2_done", 64'(r2_line_done), 64'h1);
        r2_fe_word_off = 3'd6;
        #1;
        chk("w2_off6", 64'(r2_fe_rdata), 64'h1000_0003);
        r2_fe_word_off = 3'd7;
        #1;
        chk("w2_off7", 64'(r2_fe_rdata), 64'h2000_0003);
        r2_fe_word_off = 3'd1;
        #1;
        chk("w2_off1", 64'(r2_fe_rdata), 64'h2000_0000);
        r2_fe_word_off = 3'd4;
        #1;
        chk("w2_off4", 64'(r2_fe_rdata), 64'h1000_0002);
        chk("w2_ready", 64'(r2_fe_ready), 64'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
